// File: rtl/lint32_to_axi64_bridge_pkg.sv
// Shared types and AXI encodings for the 32-bit TCDM to 64-bit AXI bridge.
package pkg_soc_interconnect;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_AWW = 3'd3,
        WR_B   = 3'd4,
        RESP   = 3'd5
    } lint2axi_state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'b011;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/lint32_to_axi64_bridge_if.sv
// TCDM slave side and AXI4 master side of the bridge, bundled in one interface.
interface lint32_to_axi64_bridge_if #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_USER_WIDTH = 6
);
    logic                      tcdm_req_i;
    logic [31:0]               tcdm_add_i;
    logic                      tcdm_wen_i;
    logic [31:0]               tcdm_wdata_i;
    logic [3:0]                tcdm_be_i;
    logic                      tcdm_gnt_o;
    logic [31:0]               tcdm_r_rdata_o;
    logic                      tcdm_r_opc_o;
    logic                      tcdm_r_valid_o;

    logic                      aw_valid_o;
    logic                      aw_ready_i;
    logic [31:0]               aw_addr_o;
    logic [AXI_ID_WIDTH-1:0]   aw_id_o;
    logic [7:0]                aw_len_o;
    logic [2:0]                aw_size_o;
    logic [1:0]                aw_burst_o;
    logic [AXI_USER_WIDTH-1:0] aw_user_o;

    logic                      w_valid_o;
    logic                      w_ready_i;
    logic [63:0]               w_data_o;
    logic [7:0]                w_strb_o;
    logic                      w_last_o;
    logic [AXI_USER_WIDTH-1:0] w_user_o;

    logic                      b_valid_i;
    logic                      b_ready_o;
    logic [1:0]                b_resp_i;
    logic [AXI_ID_WIDTH-1:0]   b_id_i;

    logic                      ar_valid_o;
    logic                      ar_ready_i;
    logic [31:0]               ar_addr_o;
    logic [AXI_ID_WIDTH-1:0]   ar_id_o;
    logic [7:0]                ar_len_o;
    logic [2:0]                ar_size_o;
    logic [1:0]                ar_burst_o;
    logic [AXI_USER_WIDTH-1:0] ar_user_o;

    logic                      r_valid_i;
    logic                      r_ready_o;
    logic [63:0]               r_data_i;
    logic [1:0]                r_resp_i;
    logic                      r_last_i;
    logic [AXI_ID_WIDTH-1:0]   r_id_i;

    modport tcdm_slave (
        input  tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_wdata_i, tcdm_be_i,
        output tcdm_gnt_o, tcdm_r_rdata_o, tcdm_r_opc_o, tcdm_r_valid_o
    );

    modport tcdm_master (
        output tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_wdata_i, tcdm_be_i,
        input  tcdm_gnt_o, tcdm_r_rdata_o, tcdm_r_opc_o, tcdm_r_valid_o
    );

    modport axi_master (
        output aw_valid_o, aw_addr_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o, aw_user_o,
        output w_valid_o, w_data_o, w_strb_o, w_last_o, w_user_o,
        output b_ready_o,
        output ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o, ar_user_o,
        output r_ready_o,
        input  aw_ready_i, w_ready_i, b_valid_i, b_resp_i, b_id_i,
        input  ar_ready_i, r_valid_i, r_data_i, r_resp_i, r_last_i, r_id_i
    );

    modport axi_slave (
        input  aw_valid_o, aw_addr_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o, aw_user_o,
        input  w_valid_o, w_data_o, w_strb_o, w_last_o, w_user_o,
        input  b_ready_o,
        input  ar_valid_o, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o, ar_user_o,
        input  r_ready_o,
        output aw_ready_i, w_ready_i, b_valid_i, b_resp_i, b_id_i,
        output ar_ready_i, r_valid_i, r_data_i, r_resp_i, r_last_i, r_id_i
    );

endinterface

// File: rtl/lint32_to_axi64_bridge.sv
// 32-bit TCDM slave to 64-bit AXI4 master; one single-beat transaction in flight at a time.
//
// state  | meaning
// IDLE   | grant follows req; request fields latched on accept
// RD_AR  | AR presented, waiting for ar_ready
// RD_R   | r_ready high, waiting for the read beat
// WR_AWW | AW and W presented, each dropped after its own handshake
// WR_B   | b_ready high, waiting for the write response
// RESP   | one-cycle TCDM response strobe
module lint32_to_axi64_bridge
    import pkg_soc_interconnect::*;
#(
    parameter int          AXI_ID_WIDTH   = 6,
    parameter int unsigned AXI_ID         = 0,
    parameter int          AXI_USER_WIDTH = 6
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    lint32_to_axi64_bridge_if.tcdm_slave       tcdm,
    lint32_to_axi64_bridge_if.axi_master       axi
);

    function automatic logic [31:0] lane_sel(input logic [63:0] data, input logic hi);
        return hi ? data[63:32] : data[31:0];
    endfunction

    function automatic logic [7:0] strb_shift(input logic [3:0] be, input logic hi);
        return hi ? {be, 4'h0} : {4'h0, be};
    endfunction

    lint2axi_state_e state_q, state_d;
    logic [31:0]     add_q, add_d;
    logic            wen_q, wen_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            opc_q, opc_d;

    logic gnt, ar_valid, r_ready, aw_valid, w_valid, b_ready, r_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            add_q     <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            opc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            add_q     <= add_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            opc_q     <= opc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        add_d     = add_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        opc_d     = opc_q;
        gnt       = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        r_valid   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Grant is masked during reset so nothing is accepted on the reset cycle.
                gnt = tcdm.tcdm_req_i & ~rst_i;
                if (gnt) begin
                    add_d     = tcdm.tcdm_add_i;
                    wen_d     = tcdm.tcdm_wen_i;
                    wdata_d   = tcdm.tcdm_wdata_i;
                    be_d      = tcdm.tcdm_be_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = tcdm.tcdm_wen_i ? RD_AR : WR_AWW;
                end
            end
            RD_AR: begin
                ar_valid = 1'b1;
                if (axi.ar_ready_i) state_d = RD_R;
            end
            RD_R: begin
                r_ready = 1'b1;
                if (axi.r_valid_i) begin
                    rdata_d = lane_sel(axi.r_data_i, add_q[2]);
                    opc_d   = axi.r_resp_i[1];
                    state_d = RESP;
                end
            end
            WR_AWW: begin
                aw_valid  = ~aw_done_q;
                w_valid   = ~w_done_q;
                aw_done_d = aw_done_q | (aw_valid & axi.aw_ready_i);
                w_done_d  = w_done_q  | (w_valid  & axi.w_ready_i);
                if (aw_done_d && w_done_d) state_d = WR_B;
            end
            WR_B: begin
                b_ready = 1'b1;
                if (axi.b_valid_i) begin
                    opc_d   = axi.b_resp_i[1];
                    state_d = RESP;
                end
            end
            RESP: begin
                r_valid = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tcdm.tcdm_gnt_o     = gnt;
    assign tcdm.tcdm_r_rdata_o = rdata_q;
    assign tcdm.tcdm_r_opc_o   = opc_q;
    assign tcdm.tcdm_r_valid_o = r_valid;

    assign axi.aw_valid_o = aw_valid;
    assign axi.aw_addr_o  = {add_q[31:3], 3'b000};
    assign axi.aw_id_o    = AXI_ID_WIDTH'(AXI_ID);
    assign axi.aw_len_o   = 8'd0;
    assign axi.aw_size_o  = SIZE_8B;
    assign axi.aw_burst_o = BURST_INCR;
    assign axi.aw_user_o  = '0;

    assign axi.w_valid_o  = w_valid;
    assign axi.w_data_o   = {wdata_q, wdata_q};
    assign axi.w_strb_o   = strb_shift(be_q, add_q[2]);
    assign axi.w_last_o   = 1'b1;
    assign axi.w_user_o   = '0;

    assign axi.b_ready_o  = b_ready;

    assign axi.ar_valid_o = ar_valid;
    assign axi.ar_addr_o  = {add_q[31:3], 3'b000};
    assign axi.ar_id_o    = AXI_ID_WIDTH'(AXI_ID);
    assign axi.ar_len_o   = 8'd0;
    assign axi.ar_size_o  = SIZE_8B;
    assign axi.ar_burst_o = BURST_INCR;
    assign axi.ar_user_o  = '0;

    assign axi.r_ready_o  = r_ready;

    // Single-beat, single-ID traffic: last, IDs and the low resp bit carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{axi.r_last_i, axi.r_id_i, axi.b_id_i,
                             axi.r_resp_i[0], axi.b_resp_i[0], add_q[1:0]};

endmodule

// File: tb/tb_lint32_to_axi64_bridge.sv
// Scoreboard bench: stimulus pushes expected TCDM/AXI results, monitors pop and compare.
module tb_lint32_to_axi64_bridge;
    import pkg_soc_interconnect::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lint32_to_axi64_bridge_if #(.AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6)) bif ();

    lint32_to_axi64_bridge #(.AXI_ID_WIDTH(6), .AXI_ID(0), .AXI_USER_WIDTH(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .tcdm  (bif),
        .axi   (bif)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        opc;
        int          lat;
        int          acc;
    } resp_t;

    resp_t       exp_resp[$];
    logic [31:0] exp_ar[$];
    logic [31:0] exp_aw[$];
    logic [63:0] exp_wd[$];
    logic [7:0]  exp_ws[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
    int grants = 0, rvalid_cnt = 0, aw_vcyc = 0, w_vcyc = 0;

    int          ar_hold = 1, aw_hold = 1, w_hold = 1, r_delay = 0, b_delay = 0;
    logic [63:0] r_data_cfg = '0;
    logic [1:0]  r_resp_cfg = RESP_OKAY;
    logic [1:0]  b_resp_cfg = RESP_OKAY;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- AXI slave responder (acts 2 time units after each edge)
    int ar_seen = 0, aw_seen = 0, w_seen = 0, r_wait = 0, b_wait = 0;
    int r_issued = 0, b_issued = 0;
    always @(posedge clk) begin
        #2;
        if (rst) begin
            bif.ar_ready_i = 0; bif.aw_ready_i = 0; bif.w_ready_i = 0;
            bif.r_valid_i = 0; bif.b_valid_i = 0;
            bif.r_data_i = '0; bif.r_resp_i = '0; bif.r_last_i = 0; bif.r_id_i = '0;
            bif.b_resp_i = '0; bif.b_id_i = '0;
            ar_seen = 0; aw_seen = 0; w_seen = 0; r_wait = 0; b_wait = 0;
            r_issued = ar_hs;
            b_issued = (aw_hs < w_hs) ? aw_hs : w_hs;
        end else begin
            if (bif.ar_ready_i) begin bif.ar_ready_i = 0; ar_seen = 0; end
            else if (bif.ar_valid_o) begin ar_seen++; if (ar_seen >= ar_hold) bif.ar_ready_i = 1; end
            if (bif.aw_ready_i) begin bif.aw_ready_i = 0; aw_seen = 0; end
            else if (bif.aw_valid_o) begin aw_seen++; if (aw_seen >= aw_hold) bif.aw_ready_i = 1; end
            if (bif.w_ready_i) begin bif.w_ready_i = 0; w_seen = 0; end
            else if (bif.w_valid_o) begin w_seen++; if (w_seen >= w_hold) bif.w_ready_i = 1; end

            if (bif.r_valid_i) begin
                if (r_hs == r_issued) bif.r_valid_i = 0;
            end else if (ar_hs > r_issued) begin
                if (r_wait >= r_delay) begin
                    bif.r_valid_i = 1; bif.r_data_i = r_data_cfg; bif.r_resp_i = r_resp_cfg;
                    bif.r_last_i = 1; r_issued++; r_wait = 0;
                end else r_wait++;
            end

            if (bif.b_valid_i) begin
                if (b_hs == b_issued) bif.b_valid_i = 0;
            end else if (aw_hs > b_issued && w_hs > b_issued) begin
                if (b_wait >= b_delay) begin
                    bif.b_valid_i = 1; bif.b_resp_i = b_resp_cfg; b_issued++; b_wait = 0;
                end else b_wait++;
            end
        end
    end

    // ---------------- Monitors (sample on the falling edge)
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bif.tcdm_req_i && bif.tcdm_gnt_o) grants++;
            if (bif.ar_valid_o || bif.aw_valid_o || bif.w_valid_o || bif.r_ready_o ||
                bif.b_ready_o || bif.tcdm_r_valid_o)
                chk("gnt_while_busy", bif.tcdm_gnt_o, 1'b0);
            if (bif.aw_valid_o) aw_vcyc++;
            if (bif.w_valid_o) w_vcyc++;

            if (bif.ar_valid_o && bif.ar_ready_i) begin
                chk("ar_outstanding", ar_hs - r_hs, 0);
                ar_hs++;
                chk("ar_attr", {bif.ar_len_o, bif.ar_size_o, bif.ar_burst_o, bif.ar_id_o, bif.ar_user_o},
                    {8'd0, 3'b011, 2'b01, 6'd0, 6'd0});
                if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                else chk("ar_addr", bif.ar_addr_o, exp_ar.pop_front());
            end
            if (bif.aw_valid_o && bif.aw_ready_i) begin
                aw_hs++;
                chk("aw_attr", {bif.aw_len_o, bif.aw_size_o, bif.aw_burst_o, bif.aw_id_o, bif.aw_user_o},
                    {8'd0, 3'b011, 2'b01, 6'd0, 6'd0});
                if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                else chk("aw_addr", bif.aw_addr_o, exp_aw.pop_front());
            end
            if (bif.w_valid_o && bif.w_ready_i) begin
                w_hs++;
                chk("w_last_user", {bif.w_last_o, bif.w_user_o}, {1'b1, 6'd0});
                if (exp_wd.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    chk("w_data", bif.w_data_o, exp_wd.pop_front());
                    chk("w_strb", bif.w_strb_o, exp_ws.pop_front());
                end
            end
            if (bif.r_valid_i && bif.r_ready_o) r_hs++;
            if (bif.b_valid_i && bif.b_ready_o) b_hs++;

            if (bif.tcdm_r_valid_o) begin
                rvalid_cnt++;
                if (exp_resp.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    chk("resp_rdata", bif.tcdm_r_rdata_o, e.rdata);
                    chk("resp_opc", bif.tcdm_r_opc_o, e.opc);
                    if (e.lat >= 0) chk("resp_latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // ---------------- Stimulus
    task automatic issue(input logic [31:0] add, input logic wen, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] exp_addr, input logic [7:0] exp_strb,
                         input logic [31:0] exp_rdata, input logic exp_opc, input int lat,
                         input bit push_resp, input bit hold);
        bit granted = 0;
        bif.tcdm_req_i = 1; bif.tcdm_add_i = add; bif.tcdm_wen_i = wen;
        bif.tcdm_wdata_i = wd; bif.tcdm_be_i = be;
        for (int n = 0; n < 200 && !granted; n++) begin
            @(negedge clk);
            if (bif.tcdm_gnt_o) granted = 1;
        end
        if (!granted) chk("grant_timeout", 0, 1);
        else begin
            resp_t e;
            e.rdata = exp_rdata; e.opc = exp_opc; e.lat = lat; e.acc = cyc;
            if (push_resp) exp_resp.push_back(e);
            if (wen) exp_ar.push_back(exp_addr);
            else begin
                exp_aw.push_back(exp_addr);
                exp_wd.push_back({wd, wd});
                exp_ws.push_back(exp_strb);
            end
        end
        @(posedge clk); #1;
        if (!hold) bif.tcdm_req_i = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_resp.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (exp_resp.size() != 0) chk("resp_timeout", exp_resp.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int aw0, w0, awh0, wh0, g0, rv0;
        bit seen_b;
        rst = 1;
        bif.tcdm_req_i = 0; bif.tcdm_add_i = '0; bif.tcdm_wen_i = 0;
        bif.tcdm_wdata_i = '0; bif.tcdm_be_i = '0;
        repeat (2) @(posedge clk);
        #1 bif.tcdm_req_i = 1;
        @(negedge clk);
        chk("reset_outputs", {bif.tcdm_gnt_o, bif.ar_valid_o, bif.aw_valid_o, bif.w_valid_o,
                              bif.r_ready_o, bif.b_ready_o, bif.tcdm_r_valid_o, bif.tcdm_r_opc_o}, 8'h00);
        chk("reset_rdata", bif.tcdm_r_rdata_o, 32'h0);
        @(posedge clk); #1;
        bif.tcdm_req_i = 0; rst = 0;
        repeat (2) @(posedge clk); #1;

        // 1: read, upper lane, minimum latency
        r_data_cfg = 64'h11223344_55667788; r_resp_cfg = RESP_OKAY;
        issue(32'h1C00_0004, 1, 32'h0, 4'h0, 32'h1C00_0000, 8'h00, 32'h1122_3344, 0, 3, 1, 0);
        wait_done();

        // 2: write, lower lane, AW and W accepted together
        issue(32'h1C00_0008, 0, 32'hCAFE_BABE, 4'b0011, 32'h1C00_0008, 8'h03, 32'h1122_3344, 0, -1, 1, 0);
        wait_done();

        // 3: AW held 5 cycles, W accepted at once, upper lane strobes
        aw_hold = 5; w_hold = 1;
        aw0 = aw_vcyc; w0 = w_vcyc; awh0 = aw_hs; wh0 = w_hs;
        issue(32'h1C00_0104, 0, 32'h1234_5678, 4'hF, 32'h1C00_0100, 8'hF0, 32'h1122_3344, 0, -1, 1, 0);
        wait_done();
        chk("aw_valid_cycles", aw_vcyc - aw0, 5);
        chk("w_valid_cycles", w_vcyc - w0, 1);
        chk("aw_handshakes", aw_hs - awh0, 1);
        chk("w_handshakes", w_hs - wh0, 1);

        // W late, AW first, be=0, SLVERR
        aw_hold = 1; w_hold = 3; b_resp_cfg = RESP_SLVERR;
        issue(32'h1C00_0010, 0, 32'hA5A5_0000, 4'h0, 32'h1C00_0010, 8'h00, 32'h1122_3344, 1, -1, 1, 0);
        wait_done();
        w_hold = 1; b_resp_cfg = RESP_OKAY;

        // 4: read with DECERR and slow AR/R
        ar_hold = 2; r_delay = 2;
        r_data_cfg = 64'hDEAD_BEEF_0BAD_F00D; r_resp_cfg = RESP_DECERR;
        issue(32'h1C00_000C, 1, 32'h0, 4'h0, 32'h1C00_0008, 8'h00, 32'hDEAD_BEEF, 1, -1, 1, 0);
        wait_done();
        ar_hold = 1; r_delay = 0; r_resp_cfg = RESP_OKAY;

        // 5: three back-to-back reads with req held high
        r_data_cfg = 64'hAAAA_BBBB_CCCC_DDDD;
        g0 = grants; rv0 = rvalid_cnt;
        issue(32'h1C00_0010, 1, 32'h0, 4'h0, 32'h1C00_0010, 8'h00, 32'hCCCC_DDDD, 0, 3, 1, 1);
        issue(32'h1C00_0014, 1, 32'h0, 4'h0, 32'h1C00_0010, 8'h00, 32'hAAAA_BBBB, 0, 3, 1, 1);
        issue(32'h1C00_0018, 1, 32'h0, 4'h0, 32'h1C00_0018, 8'h00, 32'hCCCC_DDDD, 0, 3, 1, 0);
        wait_done();
        chk("b2b_grants", grants - g0, 3);
        chk("b2b_rvalids", rvalid_cnt - rv0, 3);

        // 6: reset while waiting for B, then a normal read
        b_delay = 30;
        issue(32'h1C00_0020, 0, 32'h55AA_55AA, 4'hF, 32'h1C00_0020, 8'h0F, 32'h0, 0, -1, 0, 0);
        seen_b = 0;
        for (int n = 0; n < 50 && !seen_b; n++) begin
            @(negedge clk);
            if (bif.b_ready_o) seen_b = 1;
        end
        chk("reached_wr_b", seen_b, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;
        chk("post_reset_outputs", {bif.tcdm_gnt_o, bif.ar_valid_o, bif.aw_valid_o, bif.w_valid_o,
                                   bif.r_ready_o, bif.b_ready_o, bif.tcdm_r_valid_o, bif.tcdm_r_opc_o}, 8'h00);
        chk("post_reset_rdata", bif.tcdm_r_rdata_o, 32'h0);
        rst = 0; b_delay = 0;
        repeat (5) @(posedge clk); #1;
        r_data_cfg = 64'h0102_0304_0506_0708;
        issue(32'h1C00_0000, 1, 32'h0, 4'h0, 32'h1C00_0000, 8'h00, 32'h0506_0708, 0, 3, 1, 0);
        wait_done();

        chk("axi_queues_empty", exp_ar.size() + exp_aw.size() + exp_wd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
